// File: rtl/keystream_monitor_if.sv
// Single-lane valid/ready byte stream used on both sides of the keystream monitor.
interface keystream_monitor_if;
    logic       valid;
    logic [7:0] data;
    logic       ready;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/keystream_monitor.sv
// One-deep register slice for keystream bytes that also tracks runs of identical
// bytes and flags a stuck chaotic map once a run reaches RUN_LIMIT.
module keystream_monitor #(
    parameter int unsigned RUN_LIMIT = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                frame_start,
    keystream_monitor_if.slave  in_if,
    keystream_monitor_if.master out_if,
    output logic [7:0]          count,
    output logic                seen_single
);

    typedef enum logic [1:0] {IDLE, RUN, STUCK} state_t;

    localparam logic [8:0] LIMIT = 9'(RUN_LIMIT);

    state_t     state_q, state_d;
    logic [7:0] prev_q, prev_d;
    logic [7:0] count_q, count_d;
    logic       seen_q, seen_d;
    logic [7:0] out_data_q, out_data_d;
    logic       out_valid_q, out_valid_d;
    logic       in_ready;
    logic       acc;
    logic [8:0] count_inc;
    logic [7:0] count_sat;

    assign in_ready  = !out_valid_q || out_if.ready;
    assign acc       = in_if.valid && in_ready;
    assign count_inc = {1'b0, count_q} + 9'd1;
    assign count_sat = count_inc[8] ? 8'hFF : count_inc[7:0];

    always_comb begin
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        if (acc) begin
            out_data_d  = in_if.data;
            out_valid_d = 1'b1;
        end else if (out_if.ready) begin
            out_valid_d = 1'b0;
        end
    end

    // frame_start takes priority; an accepted byte in the same cycle opens the new frame.
    always_comb begin
        state_d = state_q;
        prev_d  = prev_q;
        count_d = count_q;
        seen_d  = seen_q;
        if (frame_start) begin
            seen_d = 1'b0;
            if (acc) begin
                prev_d  = in_if.data;
                count_d = 8'd1;
                state_d = RUN;
            end else begin
                prev_d  = 8'd0;
                count_d = 8'd0;
                state_d = IDLE;
            end
        end else if (acc) begin
            case (state_q)
                IDLE: begin
                    prev_d  = in_if.data;
                    count_d = 8'd1;
                    state_d = RUN;
                end
                RUN, STUCK: begin
                    if (in_if.data == prev_q) begin
                        count_d = count_sat;
                        if (count_inc >= LIMIT) begin
                            seen_d  = 1'b1;
                            state_d = STUCK;
                        end
                    end else begin
                        prev_d  = in_if.data;
                        count_d = 8'd1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            prev_q      <= 8'd0;
            count_q     <= 8'd0;
            seen_q      <= 1'b0;
            out_data_q  <= 8'd0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            prev_q      <= prev_d;
            count_q     <= count_d;
            seen_q      <= seen_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_if.ready  = in_ready;
    assign out_if.valid = out_valid_q;
    assign out_if.data  = out_data_q;
    assign count        = count_q;
    assign seen_single  = seen_q;

endmodule

// File: tb/tb_keystream_monitor.sv
// Directed bench for keystream_monitor: accepted bytes push their expected
// data/count/flag into a scoreboard that a separate monitor drains on output transfers.
module tb_keystream_monitor;

    typedef struct packed {
        logic [7:0] data;
        logic [7:0] cnt;
        logic       seen;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       frame_start;
    logic [7:0] count;
    logic       seen_single;

    int   n_checks;
    int   n_fail;
    exp_t sb[$];
    exp_t mon_e;

    keystream_monitor_if up_if ();
    keystream_monitor_if dn_if ();

    keystream_monitor #(.RUN_LIMIT(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .frame_start (frame_start),
        .in_if       (up_if.slave),
        .out_if      (dn_if.master),
        .count       (count),
        .seen_single (seen_single)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Presents one byte, waits (bounded) for acceptance, records the expected response.
    task automatic applyStimulus(input logic [7:0] data, input logic [7:0] exp_cnt, input logic exp_seen);
        bit accepted;
        exp_t e;
        up_if.valid = 1'b1;
        up_if.data  = data;
        accepted    = 1'b0;
        for (int i = 0; i < 50 && !accepted; i++) begin
            @(negedge clk);
            if (up_if.ready) accepted = 1'b1;
            else @(posedge clk);
        end
        if (accepted) begin
            e.data = data;
            e.cnt  = exp_cnt;
            e.seen = exp_seen;
            sb.push_back(e);
        end else begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL accept_timeout: byte 0x%0h never accepted", data);
        end
        @(posedge clk);
        #1;
        up_if.valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst && dn_if.valid && dn_if.ready) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("[TB] FAIL unexpected_output: got 0x%0h, expected no transfer", dn_if.data);
            end else begin
                mon_e = sb.pop_front();
                checkOutput("out_data", 32'(dn_if.data), 32'(mon_e.data));
                checkOutput("count", 32'(count), 32'(mon_e.cnt));
                checkOutput("seen_single", 32'(seen_single), 32'(mon_e.seen));
            end
        end
    end

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        rst         = 1'b1;
        frame_start = 1'b0;
        up_if.valid = 1'b0;
        up_if.data  = 8'h00;
        dn_if.ready = 1'b1;

        #12;
        checkOutput("rst_out_valid", 32'(dn_if.valid), 32'd0);
        checkOutput("rst_out_data", 32'(dn_if.data), 32'd0);
        checkOutput("rst_count", 32'(count), 32'd0);
        checkOutput("rst_seen", 32'(seen_single), 32'd0);
        checkOutput("rst_in_ready", 32'(up_if.ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        $display("[TB] distinct bytes back-to-back");
        applyStimulus(8'h11, 8'd1, 1'b0);
        applyStimulus(8'h22, 8'd1, 1'b0);
        applyStimulus(8'h33, 8'd1, 1'b0);

        $display("[TB] reset in the middle of a run");
        for (int k = 1; k <= 5; k++) applyStimulus(8'h3C, 8'(k), 1'b0);
        checkOutput("pre_rst_count", 32'(count), 32'd5);
        checkOutput("pre_rst_valid", 32'(dn_if.valid), 32'd1);
        sb.delete();
        rst = 1'b1;
        #1;
        checkOutput("midrst_out_valid", 32'(dn_if.valid), 32'd0);
        checkOutput("midrst_count", 32'(count), 32'd0);
        checkOutput("midrst_seen", 32'(seen_single), 32'd0);
        checkOutput("midrst_in_ready", 32'(up_if.ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        $display("[TB] run reaching the stuck limit");
        for (int k = 1; k <= 8; k++) applyStimulus(8'hA5, 8'(k), (k == 8));
        applyStimulus(8'h5A, 8'd1, 1'b1);

        $display("[TB] long run saturates");
        for (int k = 1; k <= 300; k++) applyStimulus(8'h00, (k < 255) ? 8'(k) : 8'hFF, 1'b1);

        $display("[TB] downstream stall");
        dn_if.ready = 1'b0;
        up_if.valid = 1'b1;
        up_if.data  = 8'h42;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("stall_in_ready", 32'(up_if.ready), 32'd0);
            checkOutput("stall_out_data", 32'(dn_if.data), 32'h00);
            checkOutput("stall_count", 32'(count), 32'hFF);
        end
        @(posedge clk);
        #1;
        dn_if.ready = 1'b1;
        applyStimulus(8'h42, 8'd1, 1'b1);

        $display("[TB] frame start with and without a byte");
        frame_start = 1'b1;
        applyStimulus(8'h77, 8'd1, 1'b0);
        frame_start = 1'b0;
        @(posedge clk);
        #1;
        frame_start = 1'b1;
        @(posedge clk);
        #1;
        frame_start = 1'b0;
        checkOutput("fs_idle_count", 32'(count), 32'd0);
        checkOutput("fs_idle_seen", 32'(seen_single), 32'd0);
        checkOutput("fs_idle_out_data", 32'(dn_if.data), 32'h77);
        applyStimulus(8'h00, 8'd1, 1'b0);
        applyStimulus(8'h00, 8'd2, 1'b0);

        for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
        checkOutput("sb_drain", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
